// File: rtl/legv8_seq_pkg.sv
// Shared definitions for the LEGv8 datapath sequencer.
//   - opcode enum (13..15 are illegal), ALU function-select codes, FSM states
//   - control-word field offsets for {SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}
//   - status flag index and the zero-register number
package legv8_seq_pkg;

  localparam int CW_WIDTH  = 25;
  localparam int DW_WIDTH  = 64;
  localparam int IMM_WIDTH = 12;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_ORR  = 4'd3,
    OP_EOR  = 4'd4,  OP_ADDI = 4'd5,  OP_SUBI = 4'd6,  OP_ANDI = 4'd7,
    OP_ORRI = 4'd8,  OP_LSL  = 4'd9,  OP_LSR  = 4'd10, OP_LDUR = 4'd11,
    OP_CBZ  = 4'd12
  } op_e;

  // FS[0] doubles as invert-B and carry-in, so SUB is ADD with bit 0 set.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WB, S_DONE} state_e;

  localparam int CW_EN_ALU = 0;
  localparam int CW_EN_MEM = 1;
  localparam int CW_BSEL   = 2;
  localparam int CW_FS     = 3;
  localparam int CW_MEMW   = 8;
  localparam int CW_REGW   = 9;
  localparam int CW_DA     = 10;
  localparam int CW_SB     = 15;
  localparam int CW_SA     = 20;

  localparam int         STATUS_Z = 0;
  localparam logic [4:0] XZR      = 5'd31;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_CBZ);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == 4'(OP_LSL)) || (op == 4'(OP_LSR));
  endfunction

endpackage

// File: rtl/legv8_cw_encode.sv
// Combinational op/regs -> control-word encoder.
//   op, rd, rn, rm : command fields
//   mem_wb         : 1 selects the LDUR write-back word (EN_Mem, RegWrite)
//   cw             : {SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}; 0 for illegal ops
module legv8_cw_encode
  import legv8_seq_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [4:0]          rd,
  input  logic [4:0]          rn,
  input  logic [4:0]          rm,
  input  logic                mem_wb,
  output logic [CW_WIDTH-1:0] cw
);

  logic [4:0] sa, sb, fs;
  logic       regw, bsel, en_mem, en_alu, legal;

  always_comb begin
    sa = rn; sb = rm; fs = FS_ADD;
    regw = 1'b0; bsel = 1'b0; en_mem = 1'b0; en_alu = 1'b0; legal = 1'b1;
    case (op_e'(op))
      OP_ADD:  begin fs = FS_ADD; en_alu = 1'b1; regw = 1'b1; end
      OP_SUB:  begin fs = FS_SUB; en_alu = 1'b1; regw = 1'b1; end
      OP_AND:  begin fs = FS_AND; en_alu = 1'b1; regw = 1'b1; end
      OP_ORR:  begin fs = FS_ORR; en_alu = 1'b1; regw = 1'b1; end
      OP_EOR:  begin fs = FS_EOR; en_alu = 1'b1; regw = 1'b1; end
      OP_ADDI: begin fs = FS_ADD; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      OP_SUBI: begin fs = FS_SUB; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      OP_ANDI: begin fs = FS_AND; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      OP_ORRI: begin fs = FS_ORR; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      OP_LSL:  begin fs = FS_LSL; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      OP_LSR:  begin fs = FS_LSR; bsel = 1'b1; en_alu = 1'b1; regw = 1'b1; end
      // Address add keeps SA/FS/Bsel identical in both cycles so the RAM
      // address is stable; only the bus source and write enable change.
      OP_LDUR: begin
        fs = FS_ADD; bsel = 1'b1;
        if (mem_wb) begin en_mem = 1'b1; regw = 1'b1; end
      end
      // rm | XZR puts rm on the flags without driving the bus.
      OP_CBZ:  begin sa = rm; sb = XZR; fs = FS_ORR; end
      default: legal = 1'b0;
    endcase
    if (rd == XZR) regw = 1'b0;
    cw = legal ? {sa, sb, rd, regw, 1'b0, fs, bsel, en_mem, en_alu} : '0;
  end

endmodule

// File: rtl/legv8_datapath_sequencer.sv
// Multi-cycle sequencer driving the LEGv8 datapath control word and constant.
//   clock/reset          : rising-edge clock, async active-high reset
//   cmd_*                : valid/ready micro-command (accepted only in IDLE)
//   ControlWord/constant : registered datapath controls (NOP = all zero)
//   status               : datapath flags {V,C,N,Z}, sampled at end of EXEC
//   rsp_*                : one-cycle completion pulse with status/CBZ/error info
//   perf_*               : retired/busy counters, built only with LEGV8_SEQ_PERF_EN
module legv8_datapath_sequencer
  import legv8_seq_pkg::*;
#(
  parameter int CW_W  = CW_WIDTH,
  parameter int DW    = DW_WIDTH,
  parameter int IMM_W = IMM_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rn,
  input  logic [4:0]       cmd_rm,
  input  logic [IMM_W-1:0] cmd_imm,
  output logic [CW_W-1:0]  ControlWord,
  output logic [DW-1:0]    constant,
  input  logic [3:0]       status,
  output logic             rsp_valid,
  output logic [3:0]       rsp_status,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [31:0]      perf_retired,
  output logic [31:0]      perf_busy
);

  state_e          state, state_nxt;
  logic [3:0]      op_q;
  logic [4:0]      rd_q, rn_q, rm_q;
  logic            accept, idle;
  logic [CW_W-1:0] cw_enc;

  assign idle   = (state == S_IDLE);
  assign accept = cmd_valid & cmd_ready;

  // One encoder: fed from the live command while idle (EXEC word registered
  // on accept), from the latched command afterwards (LDUR write-back word).
  legv8_cw_encode u_enc (
    .op     (idle ? cmd_op : op_q),
    .rd     (idle ? cmd_rd : rd_q),
    .rn     (idle ? cmd_rn : rn_q),
    .rm     (idle ? cmd_rm : rm_q),
    .mem_wb (!idle),
    .cw     (cw_enc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = op_legal(cmd_op) ? S_EXEC : S_DONE;
      S_EXEC:   state_nxt = (op_q == 4'(OP_LDUR)) ? S_MEM_WB : S_DONE;
      S_MEM_WB: state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_ready   <= 1'b1;
      ControlWord <= '0;
      constant    <= '0;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
    end else begin
      cmd_ready   <= (state_nxt == S_IDLE);
      rsp_valid   <= (state_nxt == S_DONE);
      ControlWord <= (accept || (state == S_EXEC && op_q == 4'(OP_LDUR))) ? cw_enc : '0;
      if (accept) begin
        op_q       <= cmd_op;
        rd_q       <= cmd_rd;
        rn_q       <= cmd_rn;
        rm_q       <= cmd_rm;
        rsp_err    <= !op_legal(cmd_op);
        rsp_status <= '0;
        rsp_zero   <= 1'b0;
        if (!op_legal(cmd_op))      constant <= '0;
        else if (op_is_shift(cmd_op)) constant <= DW'(cmd_imm[5:0]);
        else                        constant <= DW'(cmd_imm);
      end
      if (state == S_EXEC) begin
        rsp_status <= status;
        rsp_zero   <= (op_q == 4'(OP_CBZ)) & status[STATUS_Z];
      end
    end
  end

`ifdef LEGV8_SEQ_PERF_EN
  logic [31:0] retired_q, busy_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      busy_q    <= '0;
    end else begin
      if (rsp_valid) retired_q <= retired_q + 32'd1;
      if (!idle)     busy_q    <= busy_q + 32'd1;
    end
  end
  assign perf_retired = retired_q;
  assign perf_busy    = busy_q;
`else
  assign perf_retired = '0;
  assign perf_busy    = '0;
`endif

endmodule

// File: doc/legv8_datapath_sequencer.md
Name: legv8_datapath_sequencer

Overview:
- Multi-cycle controller that drives the 25-bit control word and 64-bit constant of the LEGv8 register/ALU/memory datapath.
- Accepts one micro-command at a time over a valid/ready handshake and sequences it as one or two datapath cycles.
- Reports completion, the captured ALU status and an error flag.
- Sits between the instruction decoder (or a test host) and the datapath.

Parameters:
- CW_W, 25, control word width.
- DW, 64, data/constant width.
- IMM_W, 12, command immediate width; zero-extended to DW.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode (package enum)
- cmd_rd  in  5  destination register
- cmd_rn  in  5  first source register
- cmd_rm  in  5  second source / CBZ test register
- cmd_imm  in  IMM_W  immediate / shift amount
- ControlWord  out  CW_W  {SA,SB,DA,RegWrite,MemWrite,FS[4:0],Bsel,EN_Mem,EN_ALU}
- constant  out  DW  zero-extended cmd_imm
- status  in  4  datapath flags {V,C,N,Z}
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  4  status captured in the last execute cycle
- rsp_zero  out  1  CBZ result (Z of tested register)
- rsp_err  out  1  illegal opcode
- perf_retired  out  32  completed commands (optional feature)
- perf_busy  out  32  non-IDLE cycles (optional feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, ControlWord=0 (NOP: no write, no bus drive), constant=0, rsp_*=0, counters=0. Asserting reset mid-command forces NOP immediately, with no cycle delay. The command is dropped and produces no rsp_valid.
- Output registering: all outputs are registered. The command is latched on the accept cycle (cmd_valid & cmd_ready).
- States:
  - IDLE: on accept go to EXEC, or to DONE if cmd_op is illegal.
  - EXEC: drive the op's control word for one cycle. For LDUR go to MEM_WB; otherwise go to DONE.
  - MEM_WB: hold SA/FS/Bsel/constant so the address stays stable for the synchronous RAM. Assert EN_Mem=1, EN_ALU=0, RegWrite=1, DA=rd. Go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, ControlWord=NOP. Go to IDLE.
- Latency, accept to rsp_valid: ALU/CBZ = 2 cycles; LDUR = 3 cycles; illegal = 1 cycle.
- Throughput: one command per 3 cycles (ALU/CBZ) or 4 cycles (LDUR). cmd_ready is low in EXEC, MEM_WB and DONE.
- Register ALU ops (ADD, SUB, AND, ORR, EOR): SA=rn, SB=rm, Bsel=0, EN_ALU=1, RegWrite=1.
- Immediate ALU ops (ADDI, SUBI, ANDI, ORRI, LSL, LSR): Bsel=1 and constant=imm. LSL/LSR use imm[5:0] as the shift amount.
- SUB/SUBI: FS[0]=1, which is both invert-B and carry-in.
- LDUR, EXEC cycle: FS=ADD, SA=rn, Bsel=1, EN_ALU=0, RegWrite=0.
- CBZ: SA=rm, SB=31, FS=ORR, Bsel=0, RegWrite=0, EN_ALU=0. rsp_zero = status.Z sampled at the end of EXEC.
- Zero-register writes: when rd==31, RegWrite is forced to 0 (XZR) and the command still completes normally.
- Bus and memory: EN_Mem and EN_ALU are never both 1 in any cycle. MemWrite is held 0 in this revision.
- rsp_status capture: sampled at the end of EXEC. For LDUR it carries the address-add flags. For illegal ops it is 0.
- cmd_valid outside IDLE is ignored; no queuing.

Optional Feature:
- Macro: LEGV8_SEQ_PERF_EN.
- With the macro: perf_retired increments on each rsp_valid, including errors. perf_busy increments every cycle state≠IDLE. Both wrap at 2^32 and clear on reset.
- Without the macro: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package legv8_seq_pkg holds:
  - opcode enum (ADD=0, SUB, AND, ORR, EOR, ADDI, SUBI, ANDI, ORRI, LSL, LSR, LDUR, CBZ; 13–15 illegal);
  - FS constants {AND=00000, ORR=00100, ADD=01000, SUB=01001, EOR=01100, LSL=10000, LSR=10100};
  - state enum;
  - control-word field offsets;
  - STATUS_Z=0 index;
  - XZR=31.
- One sub-module, legv8_cw_encode: a combinational op/regs → control-word function, used in both EXEC and MEM_WB.

Test Plan:
- ADD rd=3, rn=1, rm=2 accepted at cycle 0 -> cycle 1: ControlWord has SA=1, SB=2, DA=3, RegWrite=1, FS=01000, EN_ALU=1. Cycle 2: rsp_valid=1. Cycle 3: cmd_ready=1.
- SUBI rd=4, rn=4, imm=0x00A -> cycle 1: Bsel=1, constant=64'hA, FS=01001. rsp_status equals the status value driven during cycle 1.
- LDUR rd=5, rn=6, imm=8 -> cycle 1: EN_ALU=0, RegWrite=0. Cycle 2: EN_Mem=1, RegWrite=1, DA=5, FS/SA/constant unchanged. Cycle 3: rsp_valid.
- CBZ rm=7 with status=4'b0001 in EXEC -> rsp_zero=1, and RegWrite=0 throughout. Separately, ADD with rd=31 -> RegWrite stays 0.
- Illegal op 4'hF -> rsp_valid at cycle 1 with rsp_err=1 and ControlWord=0 throughout.
- Reset asserted during MEM_WB -> ControlWord=0 in the same cycle, no rsp_valid, cmd_ready=1 after release. With LEGV8_SEQ_PERF_EN, after 3 ADDs: perf_retired=3, perf_busy=6.
